// File: rtl/cache_refill_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_refill_pkg
// Purpose  : Shared types and derived constants for the cache refill
//            controller. It provides the FSM state enum, default geometry
//            constants, and helper functions. The top module uses the
//            helpers to derive its widths from its own parameters.
// Revision : 1.0 - initial release
// ============================================================================
package cache_refill_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  // Default geometry (matches the top-level parameter defaults)
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BLOCK_SIZE = 4;
  localparam int DEF_ADDR_WIDTH = 32;

  localparam int BLOCK_BYTES = DEF_BLOCK_SIZE * DEF_DATA_WIDTH / 8;
  localparam int OFFSET_BITS = $clog2(BLOCK_BYTES);
  localparam int CNT_BITS    = $clog2(DEF_BLOCK_SIZE);

  // Bits of byte offset inside one data word
  function automatic int word_offset_bits(input int dw);
    return $clog2(dw / 8);
  endfunction

  // Bits of byte offset inside one cache block
  function automatic int block_offset_bits(input int dw, input int bs);
    return $clog2(bs * dw / 8);
  endfunction

  // Width of the beat counter / word index
  function automatic int beat_cnt_bits(input int bs);
    return $clog2(bs);
  endfunction

endpackage : cache_refill_pkg
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_refill_ctrl
// Purpose  : Services data-cache misses one at a time. It optionally writes
//            back a dirty victim block word-by-word, then fetches the missing
//            block word-by-word over a req/ack memory port. It returns the
//            assembled block on fetch_data together with a one-cycle
//            fetch_enable pulse.
// Config   : `define CACHE_REFILL_CRITICAL_WORD_FIRST_EN to start the fill at
//            the requested word and wrap around the block. Without it, the
//            fill always runs from word 0 upward.
// Ports    :
//   clk, rst               - clock, synchronous active-high reset
//   req_valid/req_ready    - miss request handshake (ready only in IDLE)
//   req_addr, req_wb       - missing byte address, victim-dirty flag
//   wb_addr, wb_data       - victim block base address and contents
//   fetch_data             - refilled block (word i at [i*DATA_WIDTH +: DATA_WIDTH])
//   fetch_enable           - one-cycle pulse, fetch_data valid
//   busy                   - controller is not in IDLE
//   mem_req/mem_we/mem_addr/mem_wdata - registered memory beat request
//   mem_ack, mem_rdata     - memory beat completion and read data
// Revision : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl
  import cache_refill_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic                             req_wb,
  input  logic [ADDR_WIDTH-1:0]            wb_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] wb_data,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] fetch_data,
  output logic                             fetch_enable,
  output logic                             busy,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic                             mem_ack,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int WORD_OFF = word_offset_bits(DATA_WIDTH);
  localparam int OFF_W    = block_offset_bits(DATA_WIDTH, BLOCK_SIZE);
  localparam int CNT_W    = beat_cnt_bits(BLOCK_SIZE);
  localparam int BLK_W    = ADDR_WIDTH - OFF_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_SIZE - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                           r_state;
  logic [CNT_W-1:0]                 r_cnt;
  logic [BLK_W-1:0]                 r_wb_blk;    // victim block number
  logic [BLK_W-1:0]                 r_fill_blk;  // missing block number
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] r_wb_data;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] r_fetch_data;
  logic                             r_fetch_en;
  logic                             r_req_ready;
  logic                             r_busy;
  logic                             r_mem_req;
  logic                             r_mem_we;
  logic [ADDR_WIDTH-1:0]            r_mem_addr;
  logic [DATA_WIDTH-1:0]            r_mem_wdata;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [BLK_W-1:0] w_req_blk;
  logic [BLK_W-1:0] w_wb_blk;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_fill_w0;    // first fill word of the captured request
  logic [CNT_W-1:0] w_req_w0;     // first fill word of the incoming request
  logic [CNT_W-1:0] w_widx;       // block word index of the current fill beat
  logic [CNT_W-1:0] w_widx_nxt;   // block word index of the next fill beat
  logic             w_last;
  logic             w_unused;

  assign w_req_blk = req_addr[ADDR_WIDTH-1:OFF_W];
  assign w_wb_blk  = wb_addr[ADDR_WIDTH-1:OFF_W];
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_last    = (r_cnt == LAST_BEAT);

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
  logic [CNT_W-1:0] r_w0;

  assign w_req_w0  = req_addr[OFF_W-1:WORD_OFF];
  assign w_fill_w0 = r_w0;
`else
  assign w_req_w0  = '0;
  assign w_fill_w0 = '0;
`endif

  // The counter width equals log2(BLOCK_SIZE), so the sum wraps inside the
  // block and never carries into the block number.
  assign w_widx     = w_fill_w0 + r_cnt;
  assign w_widx_nxt = w_fill_w0 + w_cnt_nxt;

  // Byte-offset bits of the incoming addresses are not needed; the block
  // number alone defines the beat addresses.
  assign w_unused = ^{req_addr[OFF_W-1:0], wb_addr[OFF_W-1:0]};

  // Word-aligned byte address of word idx within block blk.
  function automatic logic [ADDR_WIDTH-1:0] beat_addr(
    input logic [BLK_W-1:0] blk,
    input logic [CNT_W-1:0] idx
  );
    return ADDR_WIDTH'({blk, idx}) << WORD_OFF;
  endfunction

  // --------------------------------------------------------------------------
  // FSM, beat counter and block registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_wb_blk     <= '0;
      r_fill_blk   <= '0;
      r_wb_data    <= '0;
      r_fetch_data <= '0;
      r_fetch_en   <= 1'b0;
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
      r_w0         <= '0;
`endif
    end else begin
      r_fetch_en <= 1'b0;

      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_wb_blk    <= w_wb_blk;
            r_fill_blk  <= w_req_blk;
            r_wb_data   <= wb_data;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_req_ready <= 1'b0;
            r_mem_req   <= 1'b1;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
            r_w0        <= w_req_w0;
`endif
            // The first beat is presented in the cycle right after acceptance.
            if (req_wb) begin
              r_state     <= WB;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= beat_addr(w_wb_blk, '0);
              r_mem_wdata <= wb_data[DATA_WIDTH-1:0];
            end else begin
              r_state     <= FILL;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= beat_addr(w_req_blk, w_req_w0);
            end
          end
        end

        WB: begin
          if (mem_ack) begin
            if (w_last) begin
              r_state    <= FILL;
              r_cnt      <= '0;
              r_mem_we   <= 1'b0;
              r_mem_addr <= beat_addr(r_fill_blk, w_fill_w0);
            end else begin
              r_cnt       <= w_cnt_nxt;
              r_mem_addr  <= beat_addr(r_wb_blk, w_cnt_nxt);
              r_mem_wdata <= r_wb_data[int'(w_cnt_nxt)*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end

        FILL: begin
          if (mem_ack) begin
            r_fetch_data[int'(w_widx)*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
            if (w_last) begin
              r_state    <= DONE;
              r_cnt      <= '0;
              r_mem_req  <= 1'b0;
              r_fetch_en <= 1'b1;
            end else begin
              r_cnt      <= w_cnt_nxt;
              r_mem_addr <= beat_addr(r_fill_blk, w_widx_nxt);
            end
          end
        end

        DONE: begin
          // Ready rises only on leaving DONE, so a request seen here waits
          // for the following IDLE cycle.
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
        end

        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
          r_mem_req   <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all registered)
  // --------------------------------------------------------------------------
  assign req_ready    = r_req_ready;
  assign busy         = r_busy;
  assign fetch_data   = r_fetch_data;
  assign fetch_enable = r_fetch_en;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;

endmodule : cache_refill_ctrl
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_refill_ctrl
// Purpose  : Self-checking bench for cache_refill_ctrl. It holds a table of
//            directed and random miss transactions. Each transaction is
//            expanded into its expected memory beat list and refilled block
//            from the addressing rules. The bench then drives the memory side
//            with several ack/stall patterns and compares the DUT against that
//            list.
// Config   : honours CACHE_REFILL_CRITICAL_WORD_FIRST_EN for the fill order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_refill_ctrl;

  localparam int DW  = 32;
  localparam int BS  = 4;
  localparam int AW  = 32;
  localparam int NTX = 22;
  localparam logic [31:0] MAGIC = 32'hA5A5_0000;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid;
  logic           req_ready;
  logic [AW-1:0]  req_addr;
  logic           req_wb;
  logic [AW-1:0]  wb_addr;
  logic [BS*DW-1:0] wb_data;
  logic [BS*DW-1:0] fetch_data;
  logic           fetch_enable;
  logic           busy;
  logic           mem_req;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic           mem_ack;
  logic [DW-1:0]  mem_rdata;

  cache_refill_ctrl #(
    .DATA_WIDTH(DW),
    .BLOCK_SIZE(BS),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_wb      (req_wb),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .fetch_data  (fetch_data),
    .fetch_enable(fetch_enable),
    .busy        (busy),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Transaction table
  logic [31:0]      t_addr   [NTX];
  logic             t_wb     [NTX];
  logic [31:0]      t_wbaddr [NTX];
  logic [BS*DW-1:0] t_wbdata [NTX];
  int               t_mode   [NTX];  // 0: ack always, 1: 3 stall cycles per beat, 2: random
  bit               t_intr   [NTX];  // poke a stray request during FILL, queue next in DONE

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_req(input int i);
    req_valid = 1'b1;
    req_addr  = t_addr[i];
    req_wb    = t_wb[i];
    wb_addr   = t_wbaddr[i];
    wb_data   = t_wbdata[i];
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ MAGIC;
  endfunction

  // Runs transaction i from an IDLE negedge to the negedge after DONE.
  task automatic run_txn(input int i);
    beat_t        q[$];
    beat_t        hd;
    logic [127:0] exp_blk;
    logic [31:0]  fb, wbb;
    int           w0, k, exp_lat, stall, intr_cnt, cyc;
    bit           acc, fe_due, done, ack;

    fb  = t_addr[i]   & ~32'hF;
    wbb = t_wbaddr[i] & ~32'hF;
    if (t_wb[i])
      for (int b = 0; b < BS; b++)
        q.push_back('{1'b1, wbb + 32'(4*b), t_wbdata[i][32*b +: 32]});
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    w0 = int'(t_addr[i][3:2]);
`else
    w0 = 0;
`endif
    for (int b = 0; b < BS; b++)
      q.push_back('{1'b0, fb + 32'(4*((w0 + b) % BS)), 32'h0});
    for (int b = 0; b < BS; b++)
      exp_blk[32*b +: 32] = mem_word(fb + 32'(4*b));

    // Acceptance
    acc = 0;
    cyc = 0;
    while (!acc && cyc < 20) begin
      drive_req(i);
      check("idle_mem_req", mem_req, 1'b0);
      check("idle_fetch_en", fetch_enable, 1'b0);
      if (req_ready) acc = 1;
      mem_ack   = 1'($urandom);  // must be ignored while mem_req is low
      mem_rdata = $urandom;
      tick();
      cyc++;
    end
    if (!acc) begin
      check("accept_timeout", 1'b0, 1'b1);
      req_valid = 1'b0;
      return;
    end
    req_valid = 1'b0;

    k = 0; exp_lat = q.size(); fe_due = 0; done = 0; stall = 0; intr_cnt = 0;
    while (!done && k < 400) begin
      check("busy", busy, 1'b1);
      check("req_ready_busy", req_ready, 1'b0);
      check("fetch_en", fetch_enable, fe_due);
      if (fe_due) begin
        check("fetch_data", fetch_data, exp_blk);
        check("latency", k, exp_lat);
        check("done_mem_req", mem_req, 1'b0);
        done = 1;
        if (t_intr[i] && i + 1 < NTX) drive_req(i + 1);
        else req_valid = 1'b0;
        mem_ack = 1'($urandom);
      end else if (q.size() == 0) begin
        check("mem_req_extra", mem_req, 1'b0);
        mem_ack = 1'b0;
      end else begin
        hd = q[0];
        check("mem_req", mem_req, 1'b1);
        check("mem_we", mem_we, hd.we);
        check("mem_addr", mem_addr, hd.addr);
        if (hd.we) check("mem_wdata", mem_wdata, hd.data);
        case (t_mode[i])
          0:       ack = 1;
          1:       ack = (stall >= 3);
          default: ack = ($urandom_range(0, 2) != 0);
        endcase
        mem_ack   = ack;
        mem_rdata = (ack && !hd.we) ? mem_word(hd.addr) : $urandom;
        if (ack) begin
          void'(q.pop_front());
          stall = 0;
          if (q.size() == 0) fe_due = 1;
        end else begin
          stall++;
          exp_lat++;
        end
        // Stray request while busy: must not be captured.
        if (t_intr[i] && !hd.we && intr_cnt < 2) begin
          req_valid = 1'b1;
          req_addr  = $urandom;
          req_wb    = 1'b1;
          wb_addr   = $urandom;
          wb_data   = {$urandom, $urandom, $urandom, $urandom};
          intr_cnt++;
        end else begin
          req_valid = 1'b0;
        end
      end
      tick();
      k++;
    end
    if (!done) begin
      check("txn_timeout", 1'b0, 1'b1);
      return;
    end
    check("post_busy", busy, 1'b0);
    check("post_ready", req_ready, 1'b1);
    check("post_mem_req", mem_req, 1'b0);
    check("post_fetch_en", fetch_enable, 1'b0);
    check("post_fetch_hold", fetch_data, exp_blk);
  endtask

  initial begin
    req_valid = 1'b0; req_addr = '0; req_wb = 1'b0; wb_addr = '0; wb_data = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    // Directed entries, then random ones
    t_addr[0] = 32'h0000_1234; t_wb[0] = 0; t_wbaddr[0] = 0; t_wbdata[0] = '0;
    t_mode[0] = 0; t_intr[0] = 0;
    t_addr[1] = 32'h0000_0040; t_wb[1] = 1; t_wbaddr[1] = 32'h0000_2000;
    t_wbdata[1] = {32'h44, 32'h33, 32'h22, 32'h11}; t_mode[1] = 0; t_intr[1] = 0;
    t_addr[2] = 32'h0000_1234; t_wb[2] = 0; t_wbaddr[2] = 0; t_wbdata[2] = '0;
    t_mode[2] = 1; t_intr[2] = 0;
    t_addr[3] = 32'h0000_1238; t_wb[3] = 0; t_wbaddr[3] = 0; t_wbdata[3] = '0;
    t_mode[3] = 0; t_intr[3] = 1;
    t_addr[4] = 32'hFFFF_FFF8; t_wb[4] = 1; t_wbaddr[4] = 32'hFFFF_FFF4;
    t_wbdata[4] = {$urandom, $urandom, $urandom, $urandom}; t_mode[4] = 2; t_intr[4] = 1;
    for (int i = 5; i < NTX; i++) begin
      t_addr[i]   = $urandom;
      t_wb[i]     = 1'($urandom);
      t_wbaddr[i] = $urandom;
      t_wbdata[i] = {$urandom, $urandom, $urandom, $urandom};
      t_mode[i]   = $urandom_range(0, 2);
      t_intr[i]   = (i != NTX - 1) && ($urandom_range(0, 2) == 0);
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_fetch_en", fetch_enable, 1'b0);
    check("rst_fetch_data", fetch_data, '0);
    rst = 1'b0;

    for (int i = 0; i < NTX; i++) run_txn(i);

    // Reset in the middle of a write-back
    req_valid = 1'b0;
    tick();
    drive_req(1);
    check("mwb_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    mem_ack = 1'b1;
    check("mwb_beat0", mem_addr, 32'h0000_2000);
    tick();
    check("mwb_beat1", mem_addr, 32'h0000_2004);
    check("mwb_we1", mem_we, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mwb_mem_req", mem_req, 1'b0);
    check("mwb_busy", busy, 1'b0);
    check("mwb_ready_after", req_ready, 1'b1);
    check("mwb_fetch_en", fetch_enable, 1'b0);
    for (int c = 0; c < 8; c++) begin
      mem_ack = 1'($urandom);
      tick();
      check("mwb_quiet_fe", fetch_enable, 1'b0);
      check("mwb_quiet_req", mem_req, 1'b0);
    end

    // Recovery after the aborted transfer
    run_txn(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_cache_refill_ctrl
`default_nettype wire
